// File: rtl/mul_booth_sequencer_pkg.sv
// Shared types, widths and the radix-4 Booth digit decoder for the signed multiply path.
package mul_pkg;

    localparam int MUL_W  = 32;
    localparam int PROD_W = 64;
    localparam int NUM_PP = 16;

    typedef enum logic [2:0] {
        ZERO = 3'd0,
        POS1 = 3'd1,
        POS2 = 3'd2,
        NEG1 = 3'd3,
        NEG2 = 3'd4
    } booth_digit_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REDUCE = 2'd1,
        ADD    = 2'd2,
        DONE   = 2'd3
    } mul_state_t;

    typedef logic [NUM_PP-1:0][PROD_W-1:0] pp_array_t;

    // Window is {Q[2i+1], Q[2i], Q[2i-1]}.
    function automatic booth_digit_t booth_decode(input logic [2:0] window);
        booth_digit_t digit;
        digit = ZERO;
        case (window)
            3'b000, 3'b111: digit = ZERO;
            3'b001, 3'b010: digit = POS1;
            3'b011:         digit = POS2;
            3'b100:         digit = NEG2;
            3'b101, 3'b110: digit = NEG1;
            default:        digit = ZERO;
        endcase
        return digit;
    endfunction

endpackage

// File: rtl/mul_booth_sequencer_if.sv
// Control-unit handshake plus the partial-product/tree bus of the multiply sequencer.
//
// Handshake: start is a one-cycle request taken only while busy=0 (IDLE or DONE);
// operands are sampled with it. done pulses for one cycle and hi/lo stay valid from
// that cycle until the next result. pp is stable except on an accepted start, and
// tree_sum/tree_carry are expected to be a combinational function of pp.
interface mul_booth_sequencer_if;
    import mul_pkg::*;

    logic                start;
    logic [MUL_W-1:0]    multiplicand;
    logic [MUL_W-1:0]    multiplier;
    logic                busy;
    logic                done;
    logic [MUL_W-1:0]    hi;
    logic [MUL_W-1:0]    lo;
    pp_array_t           pp;
    logic [PROD_W-1:0]   tree_sum;
    logic [PROD_W-1:0]   tree_carry;

    modport master (
        output start, multiplicand, multiplier, tree_sum, tree_carry,
        input  busy, done, hi, lo, pp
    );

    modport slave (
        input  start, multiplicand, multiplier, tree_sum, tree_carry,
        output busy, done, hi, lo, pp
    );

endinterface

// File: rtl/mul_booth_sequencer_booth_pp_gen.sv
// Combinational radix-4 Booth partial-product generator: 16 sign-extended 64-bit rows.
module booth_pp_gen
    import mul_pkg::*;
(
    input  logic [MUL_W-1:0] multiplicand,
    input  logic [MUL_W-1:0] multiplier,
    output pp_array_t        pp
);

    logic [MUL_W:0]    q_ext;
    logic [PROD_W-1:0] m_ext;
    booth_digit_t      digit;
    logic [PROD_W-1:0] row;

    assign q_ext = {multiplier, 1'b0};
    assign m_ext = {{(PROD_W-MUL_W){multiplicand[MUL_W-1]}}, multiplicand};

    // Operands are signed, so 16 digits cover Q exactly and no correction row is needed.
    always_comb begin
        pp    = '0;
        digit = ZERO;
        row   = '0;
        for (int i = 0; i < NUM_PP; i++) begin
            digit = booth_decode(q_ext[2*i +: 3]);
            case (digit)
                ZERO:    row = '0;
                POS1:    row = m_ext;
                POS2:    row = m_ext << 1;
                NEG1:    row = -m_ext;
                NEG2:    row = -(m_ext << 1);
                default: row = '0;
            endcase
            pp[i] = row << (2 * i);
        end
    end

endmodule

// File: rtl/mul_booth_sequencer.sv
// Multi-cycle sequencer for signed 32x32 MUL: Booth rows out to the CSA tree, final add to HI/LO.
module mul_booth_sequencer
    import mul_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int REG_TREE = 1
) (
    input  logic                       clk,
    input  logic                       reset,
    mul_booth_sequencer_if.slave       bus,
    output mul_state_t                 dbg_state
);

    mul_state_t          state;
    mul_state_t          state_next;
    logic                accept;
    pp_array_t           pp_comb;
    pp_array_t           pp_q;
    logic [PROD_W-1:0]   sum_q;
    logic [PROD_W-1:0]   carry_q;
    logic [2*WIDTH-1:0]  prod_q;

    booth_pp_gen u_pp_gen (
        .multiplicand (bus.multiplicand),
        .multiplier   (bus.multiplier),
        .pp           (pp_comb)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // DONE accepts a new start like IDLE, giving back-to-back operations.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (bus.start) begin
                    accept     = 1'b1;
                    state_next = REDUCE;
                end else begin
                    state_next = IDLE;
                end
            end
            REDUCE:  state_next = (REG_TREE != 0) ? ADD : DONE;
            ADD:     state_next = DONE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pp_q    <= '0;
            sum_q   <= '0;
            carry_q <= '0;
            prod_q  <= '0;
        end else begin
            if (accept) begin
                pp_q <= pp_comb;
            end
            if (state == REDUCE) begin
                if (REG_TREE != 0) begin
                    sum_q   <= bus.tree_sum;
                    carry_q <= bus.tree_carry;
                end else begin
                    prod_q <= bus.tree_sum + bus.tree_carry;
                end
            end
            if (state == ADD) begin
                prod_q <= sum_q + carry_q;
            end
        end
    end

    assign bus.pp    = pp_q;
    assign bus.busy  = (state == REDUCE) || (state == ADD);
    assign bus.done  = (state == DONE);
    assign bus.hi    = prod_q[2*WIDTH-1:WIDTH];
    assign bus.lo    = prod_q[WIDTH-1:0];
    assign dbg_state = state;

endmodule

// File: tb/tb_mul_booth_sequencer.sv
// Directed bench for both REG_TREE settings with a behavioural two-output reduction tree.
module tb_mul_booth_sequencer;
    import mul_pkg::*;

    logic       clk;
    logic       reset;
    mul_state_t dbg1;
    mul_state_t dbg0;
    int         n_compared;
    int         n_mismatched;

    mul_booth_sequencer_if bus1();
    mul_booth_sequencer_if bus0();

    mul_booth_sequencer #(.WIDTH(32), .REG_TREE(1)) dut1 (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus1),
        .dbg_state (dbg1)
    );

    mul_booth_sequencer #(.WIDTH(32), .REG_TREE(0)) dut0 (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus0),
        .dbg_state (dbg0)
    );

    // Tree stand-in: lower eight rows on one output, upper eight on the other.
    function automatic logic [63:0] tree_half(input pp_array_t p, input int base);
        logic [63:0] acc;
        acc = '0;
        for (int i = 0; i < 8; i++) acc = acc + p[base + i];
        return acc;
    endfunction

    always_comb begin
        bus1.tree_sum   = tree_half(bus1.pp, 0);
        bus1.tree_carry = tree_half(bus1.pp, 8);
        bus0.tree_sum   = tree_half(bus0.pp, 0);
        bus0.tree_carry = tree_half(bus0.pp, 8);
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start1(input logic [31:0] m, input logic [31:0] q);
        bus1.start        = 1'b1;
        bus1.multiplicand = m;
        bus1.multiplier   = q;
    endtask

    // Start in cycle 0; returns in cycle 3 (the DONE cycle) with start low, checking along the way.
    task automatic op1(input string tag, input logic [31:0] m, input logic [31:0] q,
                       input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        start1(m, q);
        tick();
        bus1.start = 1'b0;
        check({tag, "_c1_busy"}, 64'(bus1.busy), 64'd1);
        check({tag, "_c1_done"}, 64'(bus1.done), 64'd0);
        tick();
        check({tag, "_c2_busy"}, 64'(bus1.busy), 64'd1);
        tick();
        check({tag, "_c3_done"}, 64'(bus1.done), 64'd1);
        check({tag, "_c3_busy"}, 64'(bus1.busy), 64'd0);
        check({tag, "_hi"}, 64'(bus1.hi), 64'(exp_hi));
        check({tag, "_lo"}, 64'(bus1.lo), 64'(exp_lo));
    endtask

    initial begin
        n_compared        = 0;
        n_mismatched      = 0;
        reset             = 1'b1;
        bus1.start        = 1'b0;
        bus1.multiplicand = '0;
        bus1.multiplier   = '0;
        bus0.start        = 1'b0;
        bus0.multiplicand = '0;
        bus0.multiplier   = '0;
        tick();
        tick();
        reset = 1'b0;

        check("rst_state", 64'(dbg1), 64'(IDLE));
        check("rst_busy",  64'(bus1.busy), 64'd0);
        check("rst_done",  64'(bus1.done), 64'd0);
        check("rst_hi",    64'(bus1.hi), 64'd0);
        check("rst_lo",    64'(bus1.lo), 64'd0);
        check("rst_pp0",   bus1.pp[0], 64'd0);
        check("rst_state0", 64'(dbg0), 64'(IDLE));

        // 7 x 6: digit0 = -2 (row -14), digit1 = +2 (row 14<<2 = 56)
        start1(32'd7, 32'd6);
        tick();
        bus1.start = 1'b0;
        check("t1_c1_busy", 64'(bus1.busy), 64'd1);
        check("t1_c1_done", 64'(bus1.done), 64'd0);
        check("t1_pp0", bus1.pp[0], 64'hFFFF_FFFF_FFFF_FFF2);
        check("t1_pp1", bus1.pp[1], 64'h0000_0000_0000_0038);
        check("t1_pp2", bus1.pp[2], 64'h0);
        tick();
        check("t1_c2_busy", 64'(bus1.busy), 64'd1);
        check("t1_c2_done", 64'(bus1.done), 64'd0);
        tick();
        check("t1_c3_done", 64'(bus1.done), 64'd1);
        check("t1_hi", 64'(bus1.hi), 64'h0);
        check("t1_lo", 64'(bus1.lo), 64'h2A);
        tick();
        check("t1_c4_done", 64'(bus1.done), 64'd0);
        check("t1_c4_state", 64'(dbg1), 64'(IDLE));
        check("t1_hold_lo", 64'(bus1.lo), 64'h2A);

        op1("neg1sq", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001);
        tick();
        op1("minsq", 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000);
        tick();
        op1("minmax", 32'h8000_0000, 32'h7FFF_FFFF, 32'hC000_0000, 32'h8000_0000);
        tick();

        // Starts while busy are dropped; a start in the DONE cycle is taken.
        start1(32'd5, 32'd5);
        tick();
        start1(32'd100, 32'd100);
        tick();
        start1(32'd9, 32'd9);
        tick();
        bus1.start = 1'b0;
        check("ign_done", 64'(bus1.done), 64'd1);
        check("ign_hi", 64'(bus1.hi), 64'h0);
        check("ign_lo", 64'(bus1.lo), 64'd25);
        start1(32'd3, 32'hFFFF_FFFB);
        tick();
        bus1.start = 1'b0;
        check("b2b_c1_busy", 64'(bus1.busy), 64'd1);
        check("b2b_c1_done", 64'(bus1.done), 64'd0);
        check("b2b_hold_lo", 64'(bus1.lo), 64'd25);
        tick();
        check("b2b_c2_done", 64'(bus1.done), 64'd0);
        tick();
        check("b2b_c3_done", 64'(bus1.done), 64'd1);
        check("b2b_hi", 64'(bus1.hi), 64'hFFFF_FFFF);
        check("b2b_lo", 64'(bus1.lo), 64'hFFFF_FFF1);
        tick();

        // Reset in cycle 2 of an operation.
        start1(32'd7, 32'd6);
        tick();
        bus1.start = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort_state", 64'(dbg1), 64'(IDLE));
        check("abort_busy", 64'(bus1.busy), 64'd0);
        check("abort_done", 64'(bus1.done), 64'd0);
        check("abort_hi", 64'(bus1.hi), 64'h0);
        check("abort_lo", 64'(bus1.lo), 64'h0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("abort_no_done", 64'(bus1.done), 64'd0);
        end

        // Reset wins over a simultaneous start.
        reset = 1'b1;
        start1(32'd2, 32'd2);
        tick();
        reset      = 1'b0;
        bus1.start = 1'b0;
        check("rst_vs_start_state", 64'(dbg1), 64'(IDLE));
        check("rst_vs_start_busy", 64'(bus1.busy), 64'd0);
        tick();

        // Unregistered tree: done two cycles after start.
        bus0.start        = 1'b1;
        bus0.multiplicand = 32'h1234_5678;
        bus0.multiplier   = 32'h0000_0010;
        tick();
        bus0.start = 1'b0;
        check("nr_c1_busy", 64'(bus0.busy), 64'd1);
        check("nr_c1_done", 64'(bus0.done), 64'd0);
        tick();
        check("nr_c2_done", 64'(bus0.done), 64'd1);
        check("nr_c2_busy", 64'(bus0.busy), 64'd0);
        check("nr_hi", 64'(bus0.hi), 64'h0000_0001);
        check("nr_lo", 64'(bus0.lo), 64'h2345_6780);
        tick();
        check("nr_c3_done", 64'(bus0.done), 64'd0);

        bus0.start        = 1'b1;
        bus0.multiplicand = 32'hFFFF_FFF9;
        bus0.multiplier   = 32'd6;
        tick();
        bus0.start = 1'b0;
        tick();
        check("nr_neg_done", 64'(bus0.done), 64'd1);
        check("nr_neg_hi", 64'(bus0.hi), 64'hFFFF_FFFF);
        check("nr_neg_lo", 64'(bus0.lo), 64'hFFFF_FFD6);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
